// File: rtl/poscalc_ds.sv
// poscalc_ds: delta-over-sum beam-position calculator.
//
// Takes one set of four unsigned button amplitudes (A, B, C, D) and produces
// the normalised X, Y and Q (skew) positions as signed Q1.FRAC values, plus
// the full-precision sum. One restoring divider is time-shared across X, Y
// and Q, so every set takes the same number of cycles.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   val_i          amplitude set valid strobe (accepted only while rdy_o=1)
//   data_a_i..d_i  unsigned amplitudes, DATAIN_WIDTH each
//   sum_thres_i    minimum valid sum, sampled together with the amplitudes
//   rdy_o          high while idle
//   data_x_o/y/q   signed positions, DATAOUT_WIDTH each
//   data_sum_o     A+B+C+D
//   val_o          one-cycle pulse when the outputs are refreshed
//   below_thres_o  last result had sum < threshold or sum == 0
//   ovf_o          sticky: val_i arrived while busy (cleared only by reset)
module poscalc_ds #(
  parameter int DATAIN_WIDTH  = 16,
  parameter int DATAOUT_WIDTH = 16,
  parameter int SUM_WIDTH     = DATAIN_WIDTH + 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     val_i,
  input  logic [DATAIN_WIDTH-1:0]  data_a_i,
  input  logic [DATAIN_WIDTH-1:0]  data_b_i,
  input  logic [DATAIN_WIDTH-1:0]  data_c_i,
  input  logic [DATAIN_WIDTH-1:0]  data_d_i,
  input  logic [SUM_WIDTH-1:0]     sum_thres_i,
  output logic                     rdy_o,
  output logic [DATAOUT_WIDTH-1:0] data_x_o,
  output logic [DATAOUT_WIDTH-1:0] data_y_o,
  output logic [DATAOUT_WIDTH-1:0] data_q_o,
  output logic [SUM_WIDTH-1:0]     data_sum_o,
  output logic                     val_o,
  output logic                     below_thres_o,
  output logic                     ovf_o
);

  localparam int FRAC      = DATAOUT_WIDTH - 1;
  localparam int CNT_WIDTH = $clog2(DATAOUT_WIDTH + 1);
  localparam int REM_WIDTH = SUM_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE,
    SUM,
    DIV_X,
    DIV_Y,
    DIV_Q,
    OUT
  } state_t;

  state_t state, state_nxt;

  // Captured inputs
  logic [DATAIN_WIDTH-1:0] a, b, c, d;
  logic [SUM_WIDTH-1:0]    thres;

  // Registered sum stage
  logic [SUM_WIDTH-1:0]    s;
  logic [SUM_WIDTH-1:0]    ny, nq;
  logic                    neg_x;
  logic                    z;

  // Divider
  logic [REM_WIDTH-1:0]     rem;
  logic [DATAOUT_WIDTH-1:0] quo;
  logic [CNT_WIDTH-1:0]     cnt;

  // Finished lanes waiting for the common output update
  logic [DATAOUT_WIDTH-1:0] res_x, res_y;

  // Sum-stage arithmetic
  logic [SUM_WIDTH-1:0] sum_ad, sum_bc, sum_ab, sum_cd, sum_ac, sum_bd;
  logic [SUM_WIDTH-1:0] sum_all, nx_c, ny_c, nq_c;

  always_comb begin
    sum_ad  = SUM_WIDTH'(a) + SUM_WIDTH'(d);
    sum_bc  = SUM_WIDTH'(b) + SUM_WIDTH'(c);
    sum_ab  = SUM_WIDTH'(a) + SUM_WIDTH'(b);
    sum_cd  = SUM_WIDTH'(c) + SUM_WIDTH'(d);
    sum_ac  = SUM_WIDTH'(a) + SUM_WIDTH'(c);
    sum_bd  = SUM_WIDTH'(b) + SUM_WIDTH'(d);
    sum_all = sum_ad + sum_bc;
    // Two's-complement differences; each pair sum is below 2^(SUM_WIDTH-1)
    nx_c    = sum_ad - sum_bc;
    ny_c    = sum_ab - sum_cd;
    nq_c    = sum_ac - sum_bd;
  end

  // One restoring step: quotient bit, then shift the partial remainder.
  logic                     ge;
  logic [REM_WIDTH-1:0]     rem_sub;
  logic [REM_WIDTH-1:0]     rem_nxt;
  logic [DATAOUT_WIDTH-1:0] quo_nxt;
  logic                     last;

  always_comb begin
    ge      = (rem >= {1'b0, s});
    rem_sub = ge ? (rem - {1'b0, s}) : rem;
    // rem_sub < s, so its MSB is always clear and the shift loses nothing
    rem_nxt = {rem_sub[REM_WIDTH-2:0], 1'b0};
    quo_nxt = {quo[DATAOUT_WIDTH-2:0], ge};
    last    = (cnt == CNT_WIDTH'(DATAOUT_WIDTH - 1));
  end

  function automatic logic [SUM_WIDTH-1:0] mag(input logic [SUM_WIDTH-1:0] v);
    return v[SUM_WIDTH-1] ? ('0 - v) : v;
  endfunction

  // Quotient MSB set means |N| == S; clamp to the largest positive code so
  // the most negative code is never produced after negation.
  function automatic logic [DATAOUT_WIDTH-1:0] to_pos(
    input logic [DATAOUT_WIDTH-1:0] q,
    input logic                     neg,
    input logic                     zero
  );
    logic [DATAOUT_WIDTH-1:0] m;
    m = q[DATAOUT_WIDTH-1] ? {1'b0, {FRAC{1'b1}}} : q;
    if (zero) begin
      return '0;
    end
    return neg ? ('0 - m) : m;
  endfunction

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and ready
  always_comb begin
    state_nxt = state;
    rdy_o     = 1'b0;
    case (state)
      IDLE: begin
        rdy_o = 1'b1;
        if (val_i) begin
          state_nxt = SUM;
        end
      end
      SUM:   state_nxt = DIV_X;
      DIV_X: if (last) state_nxt = DIV_Y;
      DIV_Y: if (last) state_nxt = DIV_Q;
      DIV_Q: if (last) state_nxt = OUT;
      OUT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a             <= '0;
      b             <= '0;
      c             <= '0;
      d             <= '0;
      thres         <= '0;
      s             <= '0;
      ny            <= '0;
      nq            <= '0;
      neg_x         <= 1'b0;
      z             <= 1'b0;
      rem           <= '0;
      quo           <= '0;
      cnt           <= '0;
      res_x         <= '0;
      res_y         <= '0;
      data_x_o      <= '0;
      data_y_o      <= '0;
      data_q_o      <= '0;
      data_sum_o    <= '0;
      below_thres_o <= 1'b0;
      val_o         <= 1'b0;
      ovf_o         <= 1'b0;
    end else begin
      val_o <= 1'b0;

      if (val_i && (state != IDLE)) begin
        ovf_o <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (val_i) begin
            a     <= data_a_i;
            b     <= data_b_i;
            c     <= data_c_i;
            d     <= data_d_i;
            thres <= sum_thres_i;
          end
        end

        SUM: begin
          s     <= sum_all;
          ny    <= ny_c;
          nq    <= nq_c;
          neg_x <= nx_c[SUM_WIDTH-1];
          z     <= (sum_all == '0) || (sum_all < thres);
          rem   <= {1'b0, mag(nx_c)};
          quo   <= '0;
          cnt   <= '0;
        end

        DIV_X, DIV_Y, DIV_Q: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + CNT_WIDTH'(1);
          if (last) begin
            quo <= '0;
            cnt <= '0;
            case (state)
              DIV_X: begin
                res_x <= to_pos(quo_nxt, neg_x, z);
                rem   <= {1'b0, mag(ny)};
              end
              DIV_Y: begin
                res_y <= to_pos(quo_nxt, ny[SUM_WIDTH-1], z);
                rem   <= {1'b0, mag(nq)};
              end
              default: begin
                // Outputs are loaded on the edge entering OUT so that they
                // are already valid during the OUT cycle alongside val_o.
                data_x_o      <= res_x;
                data_y_o      <= res_y;
                data_q_o      <= to_pos(quo_nxt, nq[SUM_WIDTH-1], z);
                data_sum_o    <= s;
                below_thres_o <= z;
                val_o         <= 1'b1;
              end
            endcase
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poscalc_ds.sv
module tb_poscalc_ds;

  localparam int DW = 16;
  localparam int OW = 16;
  localparam int SW = DW + 2;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          val_i;
  logic [DW-1:0] data_a_i, data_b_i, data_c_i, data_d_i;
  logic [SW-1:0] sum_thres_i;
  logic          rdy_o;
  logic [OW-1:0] data_x_o, data_y_o, data_q_o;
  logic [SW-1:0] data_sum_o;
  logic          val_o, below_thres_o, ovf_o;

  poscalc_ds #(.DATAIN_WIDTH(DW), .DATAOUT_WIDTH(OW)) dut (
    .clk_i(clk), .rst_i(rst_i), .val_i(val_i),
    .data_a_i(data_a_i), .data_b_i(data_b_i), .data_c_i(data_c_i), .data_d_i(data_d_i),
    .sum_thres_i(sum_thres_i), .rdy_o(rdy_o),
    .data_x_o(data_x_o), .data_y_o(data_y_o), .data_q_o(data_q_o),
    .data_sum_o(data_sum_o), .val_o(val_o), .below_thres_o(below_thres_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] a, b, c, d;
    logic [SW-1:0] thr;
    int            x, y, q, sum;
    logic          below;
  } vec_t;

  typedef struct {
    int   x, y, q, sum;
    logic below;
    int   c0;
  } exp_t;

  exp_t sb[$];
  int   gaps[$];
  int   checks = 0;
  int   errors = 0;
  int   n_val = 0;
  int   prev_vo = 0;
  exp_t mon_e;
  vec_t tbl[10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int lane(input longint n, input longint s, input bit z);
    longint m;
    if (z) return 0;
    m = ((n < 0) ? -n : n) * 32768 / s;
    if (m > 32767) m = 32767;
    return (n < 0) ? -int'(m) : int'(m);
  endfunction

  function automatic exp_t model(input int a, input int b, input int c, input int d, input int thr);
    exp_t   e;
    longint s;
    bit     z;
    s = a + b + c + d;
    z = (s == 0) || (s < thr);
    e.x     = lane(longint'((a + d) - (b + c)), s, z);
    e.y     = lane(longint'((a + b) - (c + d)), s, z);
    e.q     = lane(longint'((a + c) - (b + d)), s, z);
    e.sum   = int'(s);
    e.below = z;
    e.c0    = 0;
    return e;
  endfunction

  // Scoreboard side: every val_o must match the oldest pending set.
  always @(negedge clk) begin
    if (!rst_i && val_o) begin
      n_val++;
      gaps.push_back(cyc - prev_vo);
      prev_vo = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_val: val_o got 1 expected 0 with no pending set (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("x",       int'($signed(data_x_o)), mon_e.x);
        chk("y",       int'($signed(data_y_o)), mon_e.y);
        chk("q",       int'($signed(data_q_o)), mon_e.q);
        chk("sum",     int'(data_sum_o), mon_e.sum);
        chk("below",   int'(below_thres_o), int'(mon_e.below));
        chk("latency", cyc - mon_e.c0, 50);
      end
    end
  end

  // Called at a negedge; waits (bounded) for rdy_o and drives one set.
  task automatic send(input int a, input int b, input int c, input int d, input int thr,
                      input int x, input int y, input int q, input int sum, input logic below);
    int   n;
    exp_t e;
    n = 0;
    while (!rdy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_wait", int'(rdy_o), 1);
    data_a_i    = DW'(a);
    data_b_i    = DW'(b);
    data_c_i    = DW'(c);
    data_d_i    = DW'(d);
    sum_thres_i = SW'(thr);
    val_i       = 1'b1;
    e = '{x, y, q, sum, below, cyc};
    sb.push_back(e);
    @(negedge clk);
    val_i = 1'b0;
  endtask

  task automatic send_model(input int a, input int b, input int c, input int d, input int thr);
    exp_t e;
    e = model(a, b, c, d, thr);
    send(a, b, c, d, thr, e.x, e.y, e.q, e.sum, e.below);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_rdy"},   int'(rdy_o), 1);
    chk({tag, "_val"},   int'(val_o), 0);
    chk({tag, "_x"},     int'(data_x_o), 0);
    chk({tag, "_y"},     int'(data_y_o), 0);
    chk({tag, "_q"},     int'(data_q_o), 0);
    chk({tag, "_sum"},   int'(data_sum_o), 0);
    chk({tag, "_below"}, int'(below_thres_o), 0);
    chk({tag, "_ovf"},   int'(ovf_o), 0);
  endtask

  initial begin
    int nv, n;

    tbl[0] = '{16'd1000, 16'd1000, 16'd1000, 16'd1000, 18'd0, 0, 0, 0, 4000, 1'b0};
    tbl[1] = '{16'd3000, 16'd1000, 16'd1000, 16'd3000, 18'd0, 16384, 0, 0, 8000, 1'b0};
    tbl[2] = '{16'd1, 16'd2, 16'd0, 16'd0, 18'd0, -10922, 32767, -10922, 3, 1'b0};
    tbl[3] = '{16'd0, 16'd0, 16'd0, 16'd4000, 18'd0, 32767, -32767, -32767, 4000, 1'b0};
    tbl[4] = '{16'd0, 16'd0, 16'd0, 16'd0, 18'd0, 0, 0, 0, 0, 1'b1};
    tbl[5] = '{16'd65535, 16'd65535, 16'd65535, 16'd65535, 18'd0, 0, 0, 0, 262140, 1'b0};
    tbl[6] = '{16'd10, 16'd10, 16'd10, 16'd10, 18'd40, 0, 0, 0, 40, 1'b0};
    tbl[7] = '{16'd100, 16'd0, 16'd0, 16'd0, 18'd101, 0, 0, 0, 100, 1'b1};
    tbl[8] = '{16'd65535, 16'd0, 16'd0, 16'd0, 18'd0, 32767, 32767, 32767, 65535, 1'b0};
    tbl[9] = '{16'd3, 16'd1, 16'd0, 16'd0, 18'd0, 16384, 32767, 16384, 4, 1'b0};

    rst_i = 1'b1;
    val_i = 1'b0;
    data_a_i = '0; data_b_i = '0; data_c_i = '0; data_d_i = '0;
    sum_thres_i = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_i = 1'b0;
    @(negedge clk);

    // Directed vectors, issued as soon as the block is ready
    for (int i = 0; i < 10; i++) begin
      send(int'(tbl[i].a), int'(tbl[i].b), int'(tbl[i].c), int'(tbl[i].d), int'(tbl[i].thr),
           tbl[i].x, tbl[i].y, tbl[i].q, tbl[i].sum, tbl[i].below);
    end
    drain();
    chk("ovf_quiet", int'(ovf_o), 0);

    // Random sets against the arithmetic model
    for (int i = 0; i < 8; i++) begin
      int hi;
      hi = (i < 3) ? 3000 : 65535;
      send_model(int'($urandom_range(0, hi)), int'($urandom_range(0, hi)),
                 int'($urandom_range(0, hi)), int'($urandom_range(0, hi)),
                 int'($urandom_range(0, 20000)));
    end
    drain();

    // val_i during the OUT cycle is dropped and flags overrun
    nv = n_val;
    send(3000, 1000, 1000, 3000, 0, 16384, 0, 0, 8000, 1'b0);
    n = 0;
    while (!val_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("out_seen", int'(val_o), 1);
    chk("out_rdy", int'(rdy_o), 0);
    data_a_i = 16'd5; data_b_i = 16'd5; data_c_i = 16'd5; data_d_i = 16'd5;
    val_i = 1'b1;
    @(negedge clk);
    val_i = 1'b0;
    repeat (60) @(negedge clk);
    chk("out_drop_vals", n_val - nv, 1);
    chk("out_drop_ovf", int'(ovf_o), 1);

    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("ovf_cleared", int'(ovf_o), 0);
    @(negedge clk);

    // Threshold plus overrun 5 cycles into the computation
    nv = n_val;
    send(10, 10, 10, 10, 100, 0, 0, 0, 40, 1'b1);
    repeat (4) @(negedge clk);
    data_a_i = 16'd5000; data_b_i = 16'd1; data_c_i = 16'd1; data_d_i = 16'd1;
    sum_thres_i = '0;
    val_i = 1'b1;
    @(negedge clk);
    val_i = 1'b0;
    chk("ovr_flag", int'(ovf_o), 1);
    drain();
    repeat (60) @(negedge clk);
    chk("ovr_one_val", n_val - nv, 1);
    chk("ovr_sticky", int'(ovf_o), 1);

    // Reset 20 cycles into a computation abandons it
    nv = n_val;
    send_model(1000, 2000, 3000, 4000, 0);
    repeat (19) @(negedge clk);
    rst_i = 1'b1;
    sb.delete();
    @(negedge clk);
    rst_i = 1'b0;
    check_cleared("midrst");
    repeat (60) @(negedge clk);
    chk("midrst_no_val", n_val - nv, 0);
    send_model(4000, 1000, 2000, 500, 1000);
    drain();

    // Back-to-back sets: one result every 51 cycles
    gaps.delete();
    send(int'(tbl[1].a), int'(tbl[1].b), int'(tbl[1].c), int'(tbl[1].d), int'(tbl[1].thr),
         tbl[1].x, tbl[1].y, tbl[1].q, tbl[1].sum, tbl[1].below);
    send(int'(tbl[2].a), int'(tbl[2].b), int'(tbl[2].c), int'(tbl[2].d), int'(tbl[2].thr),
         tbl[2].x, tbl[2].y, tbl[2].q, tbl[2].sum, tbl[2].below);
    send(int'(tbl[3].a), int'(tbl[3].b), int'(tbl[3].c), int'(tbl[3].d), int'(tbl[3].thr),
         tbl[3].x, tbl[3].y, tbl[3].q, tbl[3].sum, tbl[3].below);
    drain();
    chk("b2b_count", gaps.size(), 3);
    if (gaps.size() >= 3) begin
      chk("b2b_gap1", gaps[1], 51);
      chk("b2b_gap2", gaps[2], 51);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/poscalc_ds.md
Name: poscalc_ds

Overview:
Beam-position calculator using delta-over-sum. It sits downstream of the four per-button DDC amplitude outputs (A, B, C, D) and is the successor to the plain four-DDC position wrapper. For each valid amplitude set it produces normalised X, Y and Q (skew) positions plus the full-precision SUM. A single sequential restoring divider is time-shared across X, Y and Q, so latency is constant. The block adds an input-accept handshake, a sum threshold and a sticky overrun flag, none of which the previous generation had.

Parameters:
DATAIN_WIDTH, 16, width of each unsigned amplitude input.
DATAOUT_WIDTH, 16, width of each signed position output; the fractional width is FRAC = DATAOUT_WIDTH-1.
SUM_WIDTH, DATAIN_WIDTH+2, width of the sum and threshold (derived; do not override).

Ports:
clk_i  in  1  system clock.
rst_i  in  1  reset, synchronous, active-high.
val_i  in  1  amplitude set valid strobe.
data_a_i  in  DATAIN_WIDTH  amplitude A (unsigned).
data_b_i  in  DATAIN_WIDTH  amplitude B.
data_c_i  in  DATAIN_WIDTH  amplitude C.
data_d_i  in  DATAIN_WIDTH  amplitude D.
sum_thres_i  in  SUM_WIDTH  minimum valid sum; sampled with the data.
rdy_o  out  1  high when IDLE (a set can be accepted).
data_x_o  out  DATAOUT_WIDTH  X position, signed Q1.FRAC.
data_y_o  out  DATAOUT_WIDTH  Y position, signed.
data_q_o  out  DATAOUT_WIDTH  Q position, signed.
data_sum_o  out  SUM_WIDTH  A+B+C+D, unsigned.
val_o  out  1  one-cycle pulse: the outputs are updated.
below_thres_o  out  1  the last result had sum < threshold or sum == 0.
ovf_o  out  1  sticky: val_i arrived while busy.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous, active-high.
- Reset values: rdy_o=1; every other output is 0. FSM goes to IDLE.
- Reset mid-operation: the computation is abandoned, no val_o is issued, and ovf_o clears.

State sequence: IDLE -> SUM -> DIV_X -> DIV_Y -> DIV_Q -> OUT -> IDLE.
- IDLE: on val_i, register A..D and sum_thres_i, then go to SUM. rdy_o=0 in every state except IDLE.
- SUM: register the following, each SUM_WIDTH wide, no overflow possible:
  - S = A+B+C+D
  - Nx = (A+D)-(B+C)
  - Ny = (A+B)-(C+D)
  - Nq = (A+C)-(B+D)
  - the flag z = (S==0) | (S<thres)
- DIV_X/Y/Q: each state runs exactly DATAOUT_WIDTH iterations of a restoring divide of |N| by S, one quotient bit per cycle (MSB = 2^FRAC weight first).
  - Magnitude result: m = min(floor(|N|*2^FRAC/S), 2^FRAC-1). Saturation occurs only when |N|==S.
  - Signed result: r = N<0 ? -m : m. Range is [-(2^FRAC-1), 2^FRAC-1]; the most negative code is never produced.
  - If z is set, r=0. The divider still runs so latency stays constant.
- OUT (one cycle): load data_x_o, data_y_o, data_q_o, data_sum_o=S and below_thres_o=z; pulse val_o=1; next state IDLE (rdy_o=1 the following cycle).
- Latency: the accepting edge is cycle 0; val_o is high in cycle 3*DATAOUT_WIDTH+2 (50 cycles at the default). The throughput is one set per 3*DATAOUT_WIDTH+3 cycles.
- Outputs hold their value between val_o pulses.
- val_i while rdy_o=0: the set is dropped and ovf_o is set to 1, where it stays until rst_i. A val_i in the same cycle as OUT is also dropped, because rdy_o is 0 in that cycle.
- Divider registers:
  - remainder: SUM_WIDTH+1 bits
  - quotient: DATAOUT_WIDTH bits
  - iteration counter: clog2(DATAOUT_WIDTH+1) bits
  - the counter reloads on each DIV state entry.

Test Plan:
1. A=B=C=D=1000, thres=0 -> after 50 cycles val_o=1; x=y=q=0; sum=4000; below_thres_o=0.
2. A=3000, B=1000, C=1000, D=3000 -> x=16384, y=0, q=0, sum=8000.
3. A=1, B=2, C=0, D=0 -> x=-10922, y=32767 (saturated), q=-10922, sum=3.
4. D=4000, others 0 -> x=32767, y=-32767, q=-32767; A..D=0 -> all outputs 0, below_thres_o=1.
5. Threshold and overrun:
   - A=B=C=D=10, thres=100 -> x=y=q=0, sum=40, below_thres_o=1.
   - A second val_i 5 cycles after the first -> ovf_o=1; exactly one val_o, carrying the first set's result.
6. Reset and back-to-back:
   - rst_i asserted 20 cycles into a computation -> no val_o; all outputs 0; rdy_o=1 the next cycle; a new set then completes in 50 cycles.
   - Back-to-back sets, each issued when rdy_o=1 -> one val_o per set, spaced 51 cycles apart.
